// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the canonical bubble instruction and
// the default reset vector used when the top is not overridden.
package fetch_pkg;

  // REQ : request is offered to instruction memory
  // WAIT: request accepted, waiting for its response
  // HOLD: response parked in the skid entry because decode is stalled
  // DROP: response of a request made obsolete by a redirect is still due
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0 -- presented to decode whenever there is no real instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Purpose: one-entry instruction register (valid, instr, pc, pc+4).
// Latency: load visible on the outputs one cycle after the load edge.
// Backpressure: none of its own; the owner only loads when it may overwrite.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               invalidate the entry (highest priority)
//   load                capture load_instr/load_pc/load_pc_plus4, mark valid
//   consume             invalidate the entry when not reloaded this cycle
//   vld/instr/pc/pc_plus4  registered entry contents
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     load,
  input  logic                     consume,
  input  logic [DATA_WIDTH-1:0]    load_instr,
  input  logic [ADDRESS_WIDTH-1:0] load_pc,
  input  logic [ADDRESS_WIDTH-1:0] load_pc_plus4,
  output logic                     vld,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

  // Emptying the entry rewrites instr to a NOP but keeps pc/pc_plus4, so a
  // bubble still carries the PC of the last real instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= 1'b0;
      instr    <= DATA_WIDTH'(NOP_INSTR);
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC + ADDRESS_WIDTH'(4);
    end else if (flush) begin
      vld   <= 1'b0;
      instr <= DATA_WIDTH'(NOP_INSTR);
    end else if (load) begin
      vld      <= 1'b1;
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc_plus4;
    end else if (consume) begin
      vld   <= 1'b0;
      instr <= DATA_WIDTH'(NOP_INSTR);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: RV32I fetch stage; owns the PC and feeds decode from instruction memory.
// Latency: 2 cycles request-issue to valid_f with a zero-wait memory; 1 instr / 2 cycles.
// Backpressure: stall_d freezes the output; a one-entry skid absorbs the in-flight response.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   stall_d                        decode is not consuming this cycle
//   pc_src_e, pc_target_e          redirect from execute (target low bits ignored)
//   imem_req_valid/ready, imem_addr    request channel, one outstanding request max
//   imem_rsp_valid, imem_rsp_data      response channel, never back-pressured
//   instr_f, pc_f, pc_plus4_f, valid_f registered outputs to decode
//   fetch_cnt, bubble_cnt          performance counters, only with FETCH_PERF_EN defined
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic                     valid_f
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              bubble_cnt
`endif
);

  fetch_state_e             state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_reg, pc_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_seq, pc_redir;

  logic                     consume;
  logic                     buf_load, buf_from_skid, skid_load;
  logic [DATA_WIDTH-1:0]    buf_instr_in;
  logic [ADDRESS_WIDTH-1:0] buf_pc_in, buf_pc4_in;

  logic                     skid_vld;
  logic [DATA_WIDTH-1:0]    skid_instr;
  logic [ADDRESS_WIDTH-1:0] skid_pc, skid_pc4;

  assign consume  = valid_f && !stall_d;
  assign pc_seq   = pc_reg + ADDRESS_WIDTH'(4);
  // Misaligned redirect targets are forced onto a word boundary.
  assign pc_redir = pc_target_e & ~ADDRESS_WIDTH'(3);

  // state is already REQ while reset is held; gating with rst_n keeps the
  // request channel quiet during reset without costing a cycle afterwards.
  assign imem_req_valid = rst_n && (state == REQ);
  assign imem_addr      = pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= REQ;
      pc_reg <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc_reg <= pc_nxt;
    end
  end

  // A redirect wins over everything else in every state: the PC jumps to the
  // target and both buffers are flushed (flush is driven straight from
  // pc_src_e). The only state decision left is whether a response for the
  // old stream is still owed (go to DROP) or not (go to REQ).
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_reg;
    buf_load      = 1'b0;
    buf_from_skid = 1'b0;
    skid_load     = 1'b0;
    case (state)
      REQ: begin
        if (pc_src_e) begin
          pc_nxt    = pc_redir;
          state_nxt = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (pc_src_e) begin
          pc_nxt    = pc_redir;
          state_nxt = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          pc_nxt = pc_seq;
          if (!valid_f || consume) begin
            buf_load  = 1'b1;
            state_nxt = REQ;
          end else begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          pc_nxt    = pc_redir;
          state_nxt = REQ;
        end else if (consume && skid_vld) begin
          buf_load      = 1'b1;
          buf_from_skid = 1'b1;
          state_nxt     = REQ;
        end
      end
      DROP: begin
        if (pc_src_e) begin
          pc_nxt    = pc_redir;
          state_nxt = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  // The output buffer is refilled either from memory (pc_reg is still the
  // address of the returning request) or from the skid entry.
  always_comb begin
    buf_instr_in = imem_rsp_data;
    buf_pc_in    = pc_reg;
    buf_pc4_in   = pc_seq;
    if (buf_from_skid) begin
      buf_instr_in = skid_instr;
      buf_pc_in    = skid_pc;
      buf_pc4_in   = skid_pc4;
    end
  end

  fetch_buf #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .RESET_PC      (RESET_PC)
  ) u_out_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (pc_src_e),
    .load          (buf_load),
    .consume       (consume),
    .load_instr    (buf_instr_in),
    .load_pc       (buf_pc_in),
    .load_pc_plus4 (buf_pc4_in),
    .vld           (valid_f),
    .instr         (instr_f),
    .pc            (pc_f),
    .pc_plus4      (pc_plus4_f)
  );

  fetch_buf #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .RESET_PC      (RESET_PC)
  ) u_skid_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (pc_src_e),
    .load          (skid_load),
    .consume       (buf_from_skid),
    .load_instr    (imem_rsp_data),
    .load_pc       (pc_reg),
    .load_pc_plus4 (pc_seq),
    .vld           (skid_vld),
    .instr         (skid_instr),
    .pc            (skid_pc),
    .pc_plus4      (skid_pc4)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (consume) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (!valid_f && !stall_d) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle vector table, hand-written corner sequences
// and a randomized run scored against a program-order stream model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_d, pc_src_e, imem_req_ready;
  logic [31:0] pc_target_e;
  logic        imem_req_valid, imem_rsp_valid, valid_f;
  logic [31:0] imem_addr, imem_rsp_data, instr_f, pc_f, pc_plus4_f;

  // second instance: reset vector at the top of the address space
  logic        stall_d_2, pc_src_e_2, imem_req_ready_2;
  logic [31:0] pc_target_e_2;
  logic        imem_req_valid_2, imem_rsp_valid_2, valid_f_2;
  logic [31:0] imem_addr_2, imem_rsp_data_2, instr_f_2, pc_f_2, pc_plus4_f_2;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt_2, bubble_cnt_2;
`endif

  int checks = 0;
  int errors = 0;

  // memory model state
  bit          pend;
  int          dly;
  int          lat;
  logic [31:0] paddr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .valid_f(valid_f)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_2 (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d_2), .pc_src_e(pc_src_e_2),
    .pc_target_e(pc_target_e_2), .imem_req_valid(imem_req_valid_2),
    .imem_req_ready(imem_req_ready_2), .imem_addr(imem_addr_2),
    .imem_rsp_valid(imem_rsp_valid_2), .imem_rsp_data(imem_rsp_data_2),
    .instr_f(instr_f_2), .pc_f(pc_f_2), .pc_plus4_f(pc_plus4_f_2), .valid_f(valid_f_2)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt_2), .bubble_cnt(bubble_cnt_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a | 32'h13;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update both memory
  // models 1 time unit after it. Memory for dut_2 is always zero-wait.
  task automatic cycle();
    logic        acc, acc2;
    logic [31:0] a, a2;
    acc  = imem_req_valid && imem_req_ready;
    a    = imem_addr;
    acc2 = imem_req_valid_2 && imem_req_ready_2;
    a2   = imem_addr_2;
    if (acc) chk("one_outstanding", 32'(pend), 32'd0);
    @(posedge clk);
    #1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_valid_2 = acc2;
    imem_rsp_data_2  = mem(a2);
    if (pend) begin
      if (dly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(paddr);
        pend           = 1'b0;
      end else begin
        dly--;
      end
    end
    if (acc) begin
      if (lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(a);
      end else begin
        pend  = 1'b1;
        paddr = a;
        dly   = lat - 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall_d        = 1'b0;
    pc_src_e       = 1'b0;
    pc_target_e    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pend           = 1'b0;
    dly            = 0;
    lat            = 0;
    repeat (2) @(posedge clk);
    #1;
    imem_rsp_valid_2 = 1'b0;
    chk("rst_valid",    valid_f, 0);
    chk("rst_instr",    instr_f, NOP);
    chk("rst_pc",       pc_f, 32'h0);
    chk("rst_pc4",      pc_plus4_f, 32'h4);
    chk("rst_req",      imem_req_valid, 0);
    chk("rst_addr",     imem_addr, 32'h0);
    chk("rst2_pc",      pc_f_2, 32'hFFFF_FFFC);
    chk("rst2_pc4",     pc_plus4_f_2, 32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt [25];

  task automatic row(input int i, input logic st, input logic src, input logic [31:0] tgt,
                     input logic rdy, input logic e_vld, input logic [31:0] e_pc,
                     input logic e_req, input logic [31:0] e_addr);
    vt[i] = '{st, src, tgt, rdy, e_vld, e_pc, e_req, e_addr};
  endtask

  logic        got, seen, pv, pst, psrc;
  logic [31:0] exp_pc, ppc, pins, ptgt;
  int          ncons, nbub;

  initial begin
    stall_d_2 = 1'b0; pc_src_e_2 = 1'b0; pc_target_e_2 = 32'h0; imem_req_ready_2 = 1'b1;
    imem_rsp_valid_2 = 1'b0; imem_rsp_data_2 = 32'h0;

    //   i   stall src tgt       rdy | vld pc        req addr
    row( 0, 0, 0, 32'h0,   1,   0, 32'h0,   0, 32'h0);
    row( 1, 0, 0, 32'h0,   1,   1, 32'h0,   1, 32'h4);
    row( 2, 0, 0, 32'h0,   1,   0, 32'h0,   0, 32'h4);
    row( 3, 0, 0, 32'h0,   1,   1, 32'h4,   1, 32'h8);
    row( 4, 1, 0, 32'h0,   1,   1, 32'h4,   0, 32'h8);   // stall, response lands in skid
    row( 5, 1, 0, 32'h0,   1,   1, 32'h4,   0, 32'hC);
    row( 6, 1, 0, 32'h0,   1,   1, 32'h4,   0, 32'hC);
    row( 7, 1, 0, 32'h0,   1,   1, 32'h4,   0, 32'hC);
    row( 8, 0, 0, 32'h0,   1,   1, 32'h8,   1, 32'hC);   // skid moves up
    row( 9, 0, 0, 32'h0,   1,   0, 32'h8,   0, 32'hC);
    row(10, 0, 0, 32'h0,   1,   1, 32'hC,   1, 32'h10);
    row(11, 0, 0, 32'h0,   1,   0, 32'hC,   0, 32'h10);
    row(12, 0, 1, 32'h100, 1,   0, 32'hC,   1, 32'h100); // redirect with response
    row(13, 0, 0, 32'h0,   1,   0, 32'hC,   0, 32'h100);
    row(14, 0, 0, 32'h0,   1,   1, 32'h100, 1, 32'h104);
    row(15, 0, 0, 32'h0,   1,   0, 32'h100, 0, 32'h104);
    row(16, 0, 0, 32'h0,   1,   1, 32'h104, 1, 32'h108);
    row(17, 1, 1, 32'h103, 1,   0, 32'h104, 0, 32'h100); // misaligned, stalled, accepted
    row(18, 0, 0, 32'h0,   1,   0, 32'h104, 1, 32'h100);
    row(19, 0, 0, 32'h0,   1,   0, 32'h104, 0, 32'h100);
    row(20, 0, 0, 32'h0,   1,   1, 32'h100, 1, 32'h104);
    row(21, 1, 0, 32'h0,   0,   1, 32'h100, 1, 32'h104);
    row(22, 0, 1, 32'h200, 0,   0, 32'h100, 1, 32'h200); // redirect in REQ without ready
    row(23, 0, 0, 32'h0,   1,   0, 32'h100, 0, 32'h200);
    row(24, 0, 0, 32'h0,   1,   1, 32'h200, 1, 32'h204);

    // ---------------- vector table ----------------
    do_reset();
    chk("start_req",  imem_req_valid, 1);
    chk("start_addr", imem_addr, 32'h0);
    for (int i = 0; i < 25; i++) begin
      stall_d        = vt[i].stall;
      pc_src_e       = vt[i].src;
      pc_target_e    = vt[i].tgt;
      imem_req_ready = vt[i].rdy;
      cycle();
      chk($sformatf("vec%0d_valid", i), valid_f, vt[i].e_vld);
      chk($sformatf("vec%0d_pc", i), pc_f, vt[i].e_pc);
      chk($sformatf("vec%0d_pc4", i), pc_plus4_f, vt[i].e_pc + 32'd4);
      chk($sformatf("vec%0d_instr", i), instr_f, vt[i].e_vld ? mem(vt[i].e_pc) : NOP);
      chk($sformatf("vec%0d_req", i), imem_req_valid, vt[i].e_req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      if (i == 1) begin
        chk("wrap_first_valid", valid_f_2, 1);
        chk("wrap_first_pc",    pc_f_2, 32'hFFFF_FFFC);
        chk("wrap_first_pc4",   pc_plus4_f_2, 32'h0);
        chk("wrap_first_instr", instr_f_2, 32'hFFFF_FFFF);
        chk("wrap_next_addr",   imem_addr_2, 32'h0);
      end
      if (i == 3) begin
        chk("wrap_second_pc",  pc_f_2, 32'h0);
        chk("wrap_second_pc4", pc_plus4_f_2, 32'h4);
      end
    end
    pc_src_e = 1'b0;
    stall_d  = 1'b0;

    // ------------- redirect while WAIT, response one cycle later -------------
    do_reset();
    lat = 1;
    cycle();
    chk("wr_in_wait_req", imem_req_valid, 0);
    pc_src_e = 1'b1; pc_target_e = 32'h100;
    cycle();
    pc_src_e = 1'b0;
    chk("wr_drop_valid", valid_f, 0);
    chk("wr_drop_req",   imem_req_valid, 0);
    chk("wr_drop_addr",  imem_addr, 32'h100);
    cycle();
    chk("wr_reissue_req",   imem_req_valid, 1);
    chk("wr_reissue_addr",  imem_addr, 32'h100);
    chk("wr_reissue_valid", valid_f, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      got = valid_f;
    end
    chk("wr_arrive", got, 1);
    chk("wr_pc",     pc_f, 32'h100);
    chk("wr_instr",  instr_f, 32'h113);

    // ------------- reset asserted mid-WAIT -------------
    do_reset();
    cycle();
    cycle();
    stall_d = 1'b1; lat = 3;
    cycle();
    chk("rw_pre_valid", valid_f, 1);
    chk("rw_pre_req",   imem_req_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("rw_valid", valid_f, 0);
    chk("rw_instr", instr_f, NOP);
    chk("rw_pc",    pc_f, 32'h0);
    chk("rw_pc4",   pc_plus4_f, 32'h4);
    chk("rw_req",   imem_req_valid, 0);
    rst_n = 1'b1;
    #1;
    imem_req_ready = 1'b0; stall_d = 1'b0; lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (valid_f) seen = 1'b1;
    end
    chk("rw_stale_ignored", seen, 0);
    chk("rw_req_after",     imem_req_valid, 1);
    chk("rw_addr_after",    imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cycle();
      got = valid_f;
    end
    chk("rw_arrive", got, 1);
    chk("rw_pc0",    pc_f, 32'h0);
    chk("rw_instr0", instr_f, 32'h13);

    // ------------- randomized run against the instruction-stream model -------------
    do_reset();
    exp_pc = 32'h0;
    ncons  = 0;
    nbub   = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_d        = ($urandom_range(0, 99) < 30);
      pc_src_e       = ($urandom_range(0, 99) < 5);
      pc_target_e    = $urandom;
      imem_req_ready = ($urandom_range(0, 99) < 75);
      lat            = $urandom_range(0, 2);
      pv   = valid_f;  pst  = stall_d;  ppc  = pc_f;  pins = instr_f;
      psrc = pc_src_e; ptgt = pc_target_e;
      if (pv && !pst) begin
        chk("rnd_pc",    pc_f, exp_pc);
        chk("rnd_instr", instr_f, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ncons++;
      end
      if (!pv && !pst) nbub++;
      if (psrc) exp_pc = ptgt & ~32'h3;
      cycle();
      if (psrc) begin
        chk("rnd_flush", valid_f, 0);
      end else if (pv && pst) begin
        chk("rnd_hold_valid", valid_f, 1);
        chk("rnd_hold_pc",    pc_f, ppc);
        chk("rnd_hold_instr", instr_f, pins);
      end
      if (!valid_f) chk("rnd_bubble_nop", instr_f, NOP);
      chk("rnd_pc4", pc_plus4_f, pc_f + 32'd4);
    end
    chk("rnd_progress", 32'(ncons > 200), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt",  fetch_cnt, 32'(ncons));
    chk("perf_bubble_cnt", bubble_cnt, 32'(nbub));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
